// File: rtl/cla_word_sequencer.sv
// Purpose: adds two 4*NIBBLES-bit words on one external 4-bit CLA, one nibble per clock, LSB first.
// Latency: request accepted at edge k -> res_valid from edge k+NIBBLES; one op per NIBBLES+2 cycles.
// Backpressure: req_ready only in IDLE; result held stable in DONE until res_ready.
module cla_word_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_c,
    input  logic [3:0]             add_s,
    input  logic                   add_c4
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic [W-1:0]      r_opa;
    logic [W-1:0]      r_opb;
    logic [W-1:0]      r_sum;
    logic              r_cout;
    logic              r_req_ready;
    logic              r_res_valid;
    logic              r_busy;

    // Bit offset of the nibble currently being added.
    logic [IDXW+1:0]   w_base;
    logic              w_last;
    logic              w_run;

    assign w_base = {r_idx, 2'b00};
    assign w_last = (r_idx == IDXW'(NIBBLES - 1));
    assign w_run  = (r_state == S_RUN);

    // Adder inputs are only driven while stepping; quiet zeros otherwise.
    assign add_a = w_run ? r_opa[w_base +: 4] : 4'd0;
    assign add_b = w_run ? r_opb[w_base +: 4] : 4'd0;
    assign add_c = w_run ? r_carry : 1'b0;

    assign req_ready = r_req_ready;
    assign res_valid = r_res_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;

    // Sequencer FSM: accept, step one nibble per cycle riding the carry, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_opa       <= op_a;
                        r_opb       <= op_b;
                        r_carry     <= cin;
                        r_idx       <= '0;
                        r_sum       <= '0;
                        r_state     <= S_RUN;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: 4] <= add_s;
                    r_carry            <= add_c4;
                    if (w_last) begin
                        r_cout      <= add_c4;
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Bench for cla_word_sequencer at NIBBLES = 4, 8 and 1, each with a behavioural 4-bit adder.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected results come from whole-word arithmetic a + b + cin.
module tb_cla_word_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Carry entering nibble i of a + b + c, from plain arithmetic on the low 4*i bits.
    function automatic logic carry_into(input logic [63:0] a, input logic [63:0] b,
                                        input logic c, input int i);
        logic [63:0] mask;
        logic [63:0] t;
        mask = (64'd1 << (4 * i)) - 64'd1;
        t = (a & mask) + (b & mask) + 64'(c);
        return t[4 * i];
    endfunction

    // ---------------- NIBBLES = 4 instance ----------------
    logic        rv4 = 0, rr4 = 1, cin4 = 0;
    logic [15:0] a4 = 0, b4 = 0;
    logic        qr4, sv4, co4, bz4, ac4, c4o4;
    logic [15:0] s4;
    logic [3:0]  aa4, ab4, as4;
    assign {c4o4, as4} = 5'(aa4) + 5'(ab4) + 5'(ac4);

    cla_word_sequencer #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(qr4), .op_a(a4), .op_b(b4),
        .cin(cin4), .res_valid(sv4), .res_ready(rr4), .sum(s4), .cout(co4), .busy(bz4),
        .add_a(aa4), .add_b(ab4), .add_c(ac4), .add_s(as4), .add_c4(c4o4));

    // ---------------- NIBBLES = 8 instance ----------------
    logic        rv8 = 0, rr8 = 1, cin8 = 0;
    logic [31:0] a8 = 0, b8 = 0;
    logic        qr8, sv8, co8, bz8, ac8, c4o8;
    logic [31:0] s8;
    logic [3:0]  aa8, ab8, as8;
    assign {c4o8, as8} = 5'(aa8) + 5'(ab8) + 5'(ac8);

    cla_word_sequencer #(.NIBBLES(8)) u_dut8 (
        .clk(clk), .rst(rst), .req_valid(rv8), .req_ready(qr8), .op_a(a8), .op_b(b8),
        .cin(cin8), .res_valid(sv8), .res_ready(rr8), .sum(s8), .cout(co8), .busy(bz8),
        .add_a(aa8), .add_b(ab8), .add_c(ac8), .add_s(as8), .add_c4(c4o8));

    // ---------------- NIBBLES = 1 instance ----------------
    logic        rv1 = 0, rr1 = 1, cin1 = 0;
    logic [3:0]  a1 = 0, b1 = 0;
    logic        qr1, sv1, co1, bz1, ac1, c4o1;
    logic [3:0]  s1;
    logic [3:0]  aa1, ab1, as1;
    assign {c4o1, as1} = 5'(aa1) + 5'(ab1) + 5'(ac1);

    cla_word_sequencer #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(qr1), .op_a(a1), .op_b(b1),
        .cin(cin1), .res_valid(sv1), .res_ready(rr1), .sum(s1), .cout(co1), .busy(bz1),
        .add_a(aa1), .add_b(ab1), .add_c(ac1), .add_s(as1), .add_c4(c4o1));

    // Issue one op on the 4-nibble DUT from IDLE and wait for its result (left in DONE view).
    task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input string tag);
        logic [16:0] exp;
        int cyc;
        exp = 17'(a) + 17'(b) + 17'(c);
        check({tag, ":req_ready"}, 64'(qr4), 64'd1);
        rv4 = 1; a4 = a; b4 = b; cin4 = c;
        @(negedge clk);
        rv4 = 0; a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
        cyc = 0;
        while (!sv4 && cyc < 20) begin
            if (cyc < 4)
                check({tag, ":add_c"}, 64'(ac4), 64'(carry_into(64'(a), 64'(b), c, cyc)));
            @(negedge clk);
            cyc++;
        end
        check({tag, ":latency"}, 64'(cyc), 64'd4);
        check({tag, ":sum"},     64'(s4),  64'(exp[15:0]));
        check({tag, ":cout"},    64'(co4), 64'(exp[16]));
    endtask

    // Release the result and confirm the sequencer is back in IDLE one cycle later.
    task automatic finish4(input string tag);
        rr4 = 1;
        @(negedge clk);
        check({tag, ":res_valid_drop"}, 64'(sv4), 64'd0);
        check({tag, ":idle_ready"},     64'(qr4), 64'd1);
        check({tag, ":idle_busy"},      64'(bz4), 64'd0);
    endtask

    task automatic op8(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input string tag);
        logic [32:0] exp;
        int cyc;
        exp = 33'(a) + 33'(b) + 33'(c);
        check({tag, ":req_ready"}, 64'(qr8), 64'd1);
        rv8 = 1; a8 = a; b8 = b; cin8 = c;
        @(negedge clk);
        rv8 = 0; a8 = $urandom; b8 = $urandom;
        cyc = 0;
        while (!sv8 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ":latency"}, 64'(cyc), 64'd8);
        check({tag, ":sum"},     64'(s8),  64'(exp[31:0]));
        check({tag, ":cout"},    64'(co8), 64'(exp[32]));
        @(negedge clk);
        check({tag, ":res_valid_drop"}, 64'(sv8), 64'd0);
    endtask

    initial begin
        logic [15:0] held_sum;
        logic        held_cout;
        logic [16:0] e17;
        int cyc;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst:res_valid", 64'(sv4), 64'd0);
        check("rst:busy",      64'(bz4), 64'd0);
        check("rst:req_ready", 64'(qr4), 64'd1);
        check("rst:sum",       64'(s4),  64'd0);
        check("rst:cout",      64'(co4), 64'd0);
        check("rst:add_a",     64'(aa4), 64'd0);
        rst = 0;
        @(negedge clk);

        // Directed ops, res_ready already high: result shown for exactly one cycle
        rr4 = 1;
        start4(16'h1234, 16'h4321, 1'b0, "d1234");
        check("d1234:sum_const", 64'(s4), 64'h5555);
        finish4("d1234");
        start4(16'hFFFF, 16'h0001, 1'b0, "dripple");
        check("dripple:sum_const", 64'(s4), 64'h0000);
        check("dripple:cout_const", 64'(co4), 64'd1);
        finish4("dripple");
        start4(16'hFFFF, 16'hFFFF, 1'b1, "dallf");
        check("dallf:sum_const", 64'(s4), 64'hFFFF);
        finish4("dallf");

        // Backpressure: hold DONE for 10 cycles while requests knock
        rr4 = 0;
        start4(16'hABCD, 16'h1357, 1'b1, "bp");
        held_sum = s4;
        held_cout = co4;
        for (int i = 0; i < 10; i++) begin
            rv4 = 1; a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
            @(negedge clk);
            check("bp:sum_hold",  64'(s4),  64'(held_sum));
            check("bp:cout_hold", 64'(co4), 64'(held_cout));
            check("bp:req_ready", 64'(qr4), 64'd0);
            check("bp:res_valid", 64'(sv4), 64'd1);
        end
        rv4 = 0;
        finish4("bp");
        check("bp:sum_after_idle", 64'(s4), 64'(held_sum));
        start4(16'h0F0F, 16'h0101, 1'b0, "bp_next");
        finish4("bp_next");

        // Reset while RUN is on nibble 2
        rv4 = 1; a4 = 16'h1234; b4 = 16'h4321; cin4 = 0;
        @(negedge clk);
        rv4 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst:req_ready", 64'(qr4), 64'd1);
        check("midrst:res_valid", 64'(sv4), 64'd0);
        check("midrst:busy",      64'(bz4), 64'd0);
        check("midrst:sum",       64'(s4),  64'd0);
        start4(16'h00FF, 16'h0001, 1'b0, "postrst");
        check("postrst:sum_const", 64'(s4), 64'h0100);
        check("postrst:cout_const", 64'(co4), 64'd0);
        finish4("postrst");

        // Random regression, NIBBLES=4, with occasional consumer stalls
        for (int i = 0; i < 1000; i++) begin
            int stall;
            stall = $urandom_range(0, 3);
            rr4 = (stall == 0);
            start4(16'($urandom), 16'($urandom), 1'($urandom), "rnd4");
            held_sum = s4;
            for (int j = 0; j < stall; j++) begin
                @(negedge clk);
                check("rnd4:stall_hold", 64'(s4), 64'(held_sum));
            end
            finish4("rnd4");
        end

        // Random regression, NIBBLES=8
        op8(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "d8wrap");
        for (int i = 0; i < 1000; i++)
            op8($urandom, $urandom, 1'($urandom), "rnd8");

        // NIBBLES=1: RUN is one cycle
        check("n1:req_ready", 64'(qr1), 64'd1);
        rv1 = 1; a1 = 4'h9; b1 = 4'h8; cin1 = 1;
        @(negedge clk);
        rv1 = 0; a1 = 4'h0; b1 = 4'h0; cin1 = 0;
        check("n1:add_c", 64'(ac1), 64'd1);
        cyc = 0;
        while (!sv1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        e17 = 17'(4'h9) + 17'(4'h8) + 17'd1;
        check("n1:latency", 64'(cyc), 64'd1);
        check("n1:sum",     64'(s1),  64'(e17[3:0]));
        check("n1:cout",    64'(co1), 64'(e17[4]));
        @(negedge clk);
        check("n1:res_valid_drop", 64'(sv1), 64'd0);
        check("n1:req_ready_back", 64'(qr1), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
